// File: rtl/sync_cnt_pkg.sv
// Shared definitions for the synchronous counter family (up-counter and down-timer).
package sync_cnt_pkg;

    // Default counter / load-value width.
    localparam int unsigned DEFAULT_WIDTH = 4;

    // Count value at which the down-timer reaches terminal count.
    localparam int unsigned ZERO_COUNT = 0;

    // Down-timer control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage : sync_cnt_pkg

// File: rtl/sync_down_timer_if.sv
// Control/status bundle of the down-timer: commands from the controller, registered status back.
interface sync_down_timer_if
    import sync_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             periodic;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    // Controller side: issues commands, observes status.
    modport master (
        output load, load_val, start, pause, periodic,
        input  count, tc, busy, done
    );

    // Timer side: receives commands, drives status.
    modport slave (
        input  load, load_val, start, pause, periodic,
        output count, tc, busy, done
    );

endinterface : sync_down_timer_if

// File: rtl/sync_down_timer.sv
// Loadable synchronous down-counter/timer with one-shot, periodic (auto-reload) and pause.
// Every status output comes straight from a flop; the next-state logic computes the
// flop inputs from the *next* state so busy/done line up with the state they describe.
module sync_down_timer
    import sync_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    sync_down_timer_if.slave  tmr_if
);

    localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(ZERO_COUNT);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q,     tc_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // State and output registers; synchronous reset overrides every command.
    // NOTE: sequential state uses non-blocking (<=) so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next state, next count and terminal-count decision; priority load > start > pause > count.
    // NOTE: every signal gets a default before the branches so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (tmr_if.load) begin
            // Load wins in any state and abandons any decrement in flight; tc stays low.
            count_d  = tmr_if.load_val;
            reload_d = tmr_if.load_val;
            state_d  = tmr_if.start ? ST_RUN : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tmr_if.start) begin
                        // Count is kept; entering RUN at zero is itself a terminal count.
                        state_d = ST_RUN;
                        tc_d    = (count_q == CNT_ZERO);
                    end
                end
                ST_DONE: begin
                    if (tmr_if.start) begin
                        // Re-arm from the last loaded value.
                        state_d = ST_RUN;
                        count_d = reload_q;
                        tc_d    = (reload_q == CNT_ZERO);
                    end
                end
                ST_RUN: begin
                    if (tmr_if.pause) begin
                        state_d = ST_HOLD;
                    end else if (count_q != CNT_ZERO) begin
                        count_d = count_q - CNT_ONE;
                        tc_d    = (count_q == CNT_ONE);
                    end else if (tmr_if.periodic) begin
                        // Auto-reload; a zero reload keeps the count at 0 and pulses tc every cycle.
                        count_d = reload_q;
                        tc_d    = (reload_q == CNT_ZERO);
                    end else begin
                        // One-shot expiry: count stays at 0, never wraps.
                        state_d = ST_DONE;
                    end
                end
                ST_HOLD: begin
                    // Count frozen; decrementing resumes the cycle after returning to RUN.
                    if (!tmr_if.pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
        done_d = (state_d == ST_DONE);
    end

    assign tmr_if.count = count_q;
    assign tmr_if.tc    = tc_q;
    assign tmr_if.busy  = busy_q;
    assign tmr_if.done  = done_q;

endmodule : sync_down_timer

// File: tb/tb_sync_down_timer.sv
// Directed self-checking bench for sync_down_timer (WIDTH = 4).
module tb_sync_down_timer;
    import sync_cnt_pkg::*;

    localparam int unsigned WIDTH = 4;

    logic clk;
    logic rst;

    int n_assert;
    int n_fail;

    sync_down_timer_if #(.WIDTH(WIDTH)) tmr_bus ();

    sync_down_timer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .tmr_if (tmr_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int cnt, input bit t, input bit b, input bit d);
        check({tag, ".count"}, 32'(tmr_bus.count), 32'(cnt));
        check({tag, ".tc"},    32'(tmr_bus.tc),    32'(t));
        check({tag, ".busy"},  32'(tmr_bus.busy),  32'(b));
        check({tag, ".done"},  32'(tmr_bus.done),  32'(d));
    endtask

    initial begin
        logic [WIDTH-1:0] per_seq [7];

        n_assert = 0;
        n_fail   = 0;
        tmr_bus.load     = 1'b0;
        tmr_bus.load_val = '0;
        tmr_bus.start    = 1'b0;
        tmr_bus.pause    = 1'b0;
        tmr_bus.periodic = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        expect_out("reset_init", 0, 0, 0, 0);

        // One-shot of 5.
        tmr_bus.load_val = 4'd5;
        tmr_bus.load     = 1'b1;
        tick();
        tmr_bus.load = 1'b0;
        expect_out("os_loaded", 5, 0, 0, 0);
        tmr_bus.start = 1'b1;
        tick();
        tmr_bus.start = 1'b0;
        expect_out("os_c5", 5, 0, 1, 0);
        for (int c = 4; c >= 1; c--) begin
            tick();
            expect_out($sformatf("os_c%0d", c), c, 0, 1, 0);
        end
        tick();
        expect_out("os_c0_tc", 0, 1, 1, 0);
        tick();
        expect_out("os_done", 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out($sformatf("os_hold%0d", i), 0, 0, 0, 1);
        end

        // Periodic with reload 2, load+start together: 2,1,0,2,1,0,...
        tmr_bus.load_val = 4'd2;
        tmr_bus.load     = 1'b1;
        tmr_bus.start    = 1'b1;
        tmr_bus.periodic = 1'b1;
        tick();
        tmr_bus.load  = 1'b0;
        tmr_bus.start = 1'b0;
        expect_out("per_c2", 2, 0, 1, 0);
        per_seq = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1};
        for (int i = 0; i < 7; i++) begin
            tick();
            expect_out($sformatf("per_%0d", i), int'(per_seq[i]), per_seq[i] == 4'd0, 1, 0);
        end

        // Synchronous reset mid-run at count 3.
        tmr_bus.periodic = 1'b0;
        tmr_bus.load_val = 4'd5;
        tmr_bus.load     = 1'b1;
        tmr_bus.start    = 1'b1;
        tick();
        tmr_bus.load  = 1'b0;
        tmr_bus.start = 1'b0;
        tick();
        tick();
        expect_out("rst_pre", 3, 0, 1, 0);
        rst = 1'b1;
        tick();
        expect_out("rst_cyc1", 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        expect_out("rst_cyc2", 0, 0, 0, 0);
        tick();
        expect_out("rst_idle", 0, 0, 0, 0);

        // Pause: one-shot of 6, hold at 4 for three cycles (start during HOLD ignored).
        tmr_bus.load_val = 4'd6;
        tmr_bus.load     = 1'b1;
        tmr_bus.start    = 1'b1;
        tick();
        tmr_bus.load  = 1'b0;
        tmr_bus.start = 1'b0;
        expect_out("pz_c6", 6, 0, 1, 0);
        tick();
        tick();
        expect_out("pz_c4", 4, 0, 1, 0);
        tmr_bus.pause = 1'b1;
        tick();
        expect_out("pz_hold0", 4, 0, 1, 0);
        tmr_bus.start = 1'b1;
        tick();
        tmr_bus.start = 1'b0;
        expect_out("pz_hold1", 4, 0, 1, 0);
        tick();
        expect_out("pz_hold2", 4, 0, 1, 0);
        tmr_bus.pause = 1'b0;
        tick();
        expect_out("pz_resume", 4, 0, 1, 0);
        for (int c = 3; c >= 1; c--) begin
            tick();
            expect_out($sformatf("pz_c%0d", c), c, 0, 1, 0);
        end
        tick();
        expect_out("pz_c0_tc", 0, 1, 1, 0);
        tick();
        expect_out("pz_done", 0, 0, 0, 1);

        // Load override in RUN at count 7.
        tmr_bus.load_val = 4'd9;
        tmr_bus.load     = 1'b1;
        tmr_bus.start    = 1'b1;
        tick();
        tmr_bus.load  = 1'b0;
        tmr_bus.start = 1'b0;
        tick();
        tick();
        expect_out("ld_c7", 7, 0, 1, 0);
        tmr_bus.load_val = 4'd3;
        tmr_bus.load     = 1'b1;
        tick();
        tmr_bus.load = 1'b0;
        expect_out("ld_idle3", 3, 0, 0, 0);
        tick();
        expect_out("ld_stay3", 3, 0, 0, 0);
        tmr_bus.start = 1'b1;
        tick();
        tmr_bus.start = 1'b0;
        expect_out("ld_run3", 3, 0, 1, 0);
        tick();
        expect_out("ld_c2", 2, 0, 1, 0);
        tick();
        expect_out("ld_c1", 1, 0, 1, 0);
        tick();
        expect_out("ld_c0_tc", 0, 1, 1, 0);
        tick();
        expect_out("ld_done", 0, 0, 0, 1);

        // Zero start, one-shot.
        tmr_bus.load_val = 4'd0;
        tmr_bus.load     = 1'b1;
        tick();
        tmr_bus.load = 1'b0;
        expect_out("z_loaded", 0, 0, 0, 0);
        tmr_bus.start = 1'b1;
        tick();
        tmr_bus.start = 1'b0;
        expect_out("z_os_tc", 0, 1, 1, 0);
        tick();
        expect_out("z_os_done", 0, 0, 0, 1);

        // Zero start, periodic: restart from DONE with reload 0 -> tc every cycle.
        tmr_bus.periodic = 1'b1;
        tmr_bus.start    = 1'b1;
        tick();
        tmr_bus.start = 1'b0;
        expect_out("z_per_tc0", 0, 1, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            expect_out($sformatf("z_per_tc%0d", i), 0, 1, 1, 0);
        end
        tmr_bus.periodic = 1'b0;
        tick();
        expect_out("z_per_stop", 0, 0, 0, 1);

        // Full-range load value.
        tmr_bus.load_val = 4'd15;
        tmr_bus.load     = 1'b1;
        tmr_bus.start    = 1'b1;
        tick();
        tmr_bus.load  = 1'b0;
        tmr_bus.start = 1'b0;
        expect_out("max_c15", 15, 0, 1, 0);
        tick();
        expect_out("max_c14", 14, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_sync_down_timer

// File: doc/sync_down_timer.md
Name: sync_down_timer

Overview:
Loadable synchronous down-counter/timer, the count-down counterpart of the team's free-running up-counter.
- Counts a programmed value down to zero and flags terminal count.
- Runs in one-shot or periodic (auto-reload) mode; supports pause.
- Used as the delay and timeout source for control logic elsewhere in the design.

Parameters:
WIDTH, 4, bit width of the counter and the load value.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
load  in  1  one-cycle strobe; captures load_val
load_val  in  WIDTH  value to count down from
start  in  1  one-cycle strobe; begins counting
pause  in  1  level; freezes the count while high in RUN
periodic  in  1  1 = auto-reload at zero, 0 = one-shot
count  out  WIDTH  current count value (registered)
tc  out  1  terminal-count pulse, one cycle, registered
busy  out  1  high in RUN or HOLD
done  out  1  high in DONE (one-shot expired)

Behaviour:
- Reset: rst is synchronous, active-high. It forces state=IDLE, count=0, reload register=0, tc=0, busy=0, done=0. It overrides every other input, including mid-run.
- States: IDLE, RUN, HOLD, DONE. All outputs are registered.
- Priority each cycle: rst > load > start > pause > count.
- load (any state):
  - count <= load_val and reload_reg <= load_val.
  - If start is high in the same cycle, next state = RUN; otherwise next state = IDLE.
  - done is cleared.
  - An in-progress decrement is abandoned and tc is not asserted that cycle.
- start in IDLE or DONE: next state = RUN and done cleared. The count is not reloaded by start alone. If in DONE, count is reloaded from reload_reg.
- start in RUN or HOLD: ignored.
- RUN, count > 0: count <= count-1 each cycle.
  - On the transition 1 -> 0, tc=1 in the same cycle in which count shows 0.
- RUN, count == 0, including after start with a zero value:
  - periodic=1: count <= reload_reg and tc=0; stay in RUN. Period = reload_reg+1 cycles between tc pulses.
  - periodic=0: next state = DONE, done=1, busy=0, count holds 0.
  - periodic is sampled only at this zero-count decision point.
- Start with count == 0 on entry: first RUN cycle sees zero. tc=1 on the cycle after start, then the zero-count rules above apply.
- reload_reg == 0 with periodic=1: count stays 0 and tc=1 every cycle. This is legal and must not underflow.
- pause high in RUN: next state = HOLD. count and tc are frozen (tc=0 in HOLD). pause low in HOLD returns to RUN, and decrementing resumes on the next cycle.
- No underflow ever: count never wraps from 0 to all-ones.
- tc is never high for more than one consecutive cycle, except in the reload_reg == 0 periodic case.
- Width rules: all arithmetic is WIDTH-bit unsigned, and load_val is the full range 0..2^WIDTH-1.

Decomposition:
- Shared package sync_cnt_pkg holds:
  - the state typedef (IDLE/RUN/HOLD/DONE);
  - the default WIDTH constant;
  - the localparam for zero count.
- No sub-module: the next-state and next-count logic fit naturally in one module of roughly 150-200 lines. The up-counter and this block share only the package.

Test Plan:
- Reset: drive rst for 2 cycles mid-run (count=3) -> next cycle count=0, busy=0, done=0, tc=0, state IDLE.
- One-shot: load_val=5, load, then start, periodic=0 -> count 5,4,3,2,1,0; tc=1 only on the count=0 cycle; next cycle done=1, busy=0; count holds 0 for 10 further cycles.
- Periodic: load_val=2 with load+start in the same cycle, periodic=1 -> count 2,1,0,2,1,0,...; tc every 3rd cycle; done never set.
- Pause: one-shot load_val=6; at count=4 hold pause high for 3 cycles -> count stays 4, tc=0, busy=1; after release count 3,2,1,0 and tc at 0.
- Load override: in RUN at count=7, load with load_val=3 and no start -> state IDLE, count=3, no tc; a later start counts 3,2,1,0.
- Zero start: load_val=0, start, periodic=0 -> tc=1 the cycle after start, then done=1. Repeat with periodic=1 -> tc high every cycle and count stays 0.
